// File: rtl/block_compare_ctrl.sv
// block_compare_ctrl: compares two equal-length word buffers held in external
// memories, reading one word from each per READ/COMPARE pair, stopping at the
// first mismatch.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   start          request a run (sampled only in IDLE)
//   abort          synchronous cancel of a run in READ or COMPARE
//   base_a/base_b  buffer start addresses, captured on an accepted start
//   len            word count, captured on an accepted start
//   rd_en          read strobe to both memories (high only in READ)
//   addr_a/addr_b  read addresses, valid while rd_en=1
//   rd_data_a/b    read data, valid the cycle after rd_en
//   busy           high in READ and COMPARE
//   done           one-cycle pulse when a run completes
//   equal          result of the last completed run
//   mismatch_idx   index of the first mismatching word of the last run
module block_compare_ctrl #(
  parameter int unsigned N  = 32,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base_a,
  input  logic [AW-1:0] base_b,
  input  logic [AW-1:0] len,
  output logic          rd_en,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  input  logic [N-1:0]  rd_data_a,
  input  logic [N-1:0]  rd_data_b,
  output logic          busy,
  output logic          done,
  output logic          equal,
  output logic [AW-1:0] mismatch_idx
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] base_a_q, base_a_d;
  logic [AW-1:0] base_b_q, base_b_d;
  logic [AW-1:0] len_q, len_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] addr_a_q, addr_a_d;
  logic [AW-1:0] addr_b_q, addr_b_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          equal_q, equal_d;
  logic [AW-1:0] mismatch_idx_q, mismatch_idx_d;

  // Single shared word comparator used by every COMPARE cycle.
  logic words_eq_c;
  assign words_eq_c = (rd_data_a == rd_data_b);

  logic last_word_c;
  assign last_word_c = (idx_q == AW'(len_q - AW'(1)));

  // Next-state, run bookkeeping and result capture.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    base_a_d       = base_a_q;
    base_b_d       = base_b_q;
    len_d          = len_q;
    equal_d        = equal_q;
    mismatch_idx_d = mismatch_idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            base_a_d = base_a;
            base_b_d = base_b;
            len_d    = len;
            idx_d    = '0;
            state_d  = S_READ;
          end else begin
            equal_d        = 1'b1;
            mismatch_idx_d = '0;
            state_d        = S_DONE;
          end
        end
      end
      S_READ: begin
        state_d = abort ? S_IDLE : S_COMPARE;
      end
      S_COMPARE: begin
        // abort wins over whatever the comparator says this cycle
        if (abort) begin
          state_d = S_IDLE;
        end else if (!words_eq_c) begin
          equal_d        = 1'b0;
          mismatch_idx_d = idx_q;
          state_d        = S_DONE;
        end else if (last_word_c) begin
          equal_d        = 1'b1;
          mismatch_idx_d = '0;
          state_d        = S_DONE;
        end else begin
          idx_d   = AW'(idx_q + AW'(1));
          state_d = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // they describe once registered.
  always_comb begin
    rd_en_d  = (state_d == S_READ);
    busy_d   = (state_d == S_READ) || (state_d == S_COMPARE);
    done_d   = (state_d == S_DONE);
    addr_a_d = AW'(base_a_d + idx_d);
    addr_b_d = AW'(base_b_d + idx_d);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      base_a_q       <= '0;
      base_b_q       <= '0;
      len_q          <= '0;
      rd_en_q        <= 1'b0;
      addr_a_q       <= '0;
      addr_b_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      equal_q        <= 1'b0;
      mismatch_idx_q <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      base_a_q       <= base_a_d;
      base_b_q       <= base_b_d;
      len_q          <= len_d;
      rd_en_q        <= rd_en_d;
      addr_a_q       <= addr_a_d;
      addr_b_q       <= addr_b_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      equal_q        <= equal_d;
      mismatch_idx_q <= mismatch_idx_d;
    end
  end

  assign rd_en        = rd_en_q;
  assign addr_a       = addr_a_q;
  assign addr_b       = addr_b_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign equal        = equal_q;
  assign mismatch_idx = mismatch_idx_q;

endmodule

// File: tb/tb_block_compare_ctrl.sv
// Testbench for block_compare_ctrl: two behavioural memories with one-cycle
// read latency, directed scenarios plus randomized runs, each checked against
// a word-level reference model of the buffer comparison.
module tb_block_compare_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [7:0]  base_a_i = '0;
  logic [7:0]  base_b_i = '0;
  logic [7:0]  len_i = '0;
  logic [31:0] rd_data_a = '0;
  logic [31:0] rd_data_b = '0;
  logic        rd_en;
  logic [7:0]  addr_a;
  logic [7:0]  addr_b;
  logic        busy;
  logic        done;
  logic        equal;
  logic [7:0]  mismatch_idx;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  logic [7:0]  obs_a [$];
  logic [7:0]  obs_b [$];
  logic        obs_busy [$];
  logic [7:0]  exp_a [$];
  logic [7:0]  exp_b [$];

  int n_checks = 0;
  int n_errors = 0;

  block_compare_ctrl #(.N(32), .AW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start_i),
    .abort        (abort_i),
    .base_a       (base_a_i),
    .base_b       (base_b_i),
    .len          (len_i),
    .rd_en        (rd_en),
    .addr_a       (addr_a),
    .addr_b       (addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .busy         (busy),
    .done         (done),
    .equal        (equal),
    .mismatch_idx (mismatch_idx)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[addr_a];
      rd_data_b <= mem_b[addr_b];
    end
  end

  // Random contents, with B made to equal A over the first ln words.
  task automatic prep(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] ln);
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
    for (int i = 0; i < int'(ln); i++)
      mem_b[8'(int'(bb) + i)] = mem_a[8'(int'(ba) + i)];
  endtask

  // Reference: scan words until the first difference; each word read costs a
  // read cycle and a compare cycle, then one cycle to report.
  task automatic model(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] ln,
                       output logic eq, output logic [7:0] mi, output int cyc, output int reads);
    eq = 1'b1;
    mi = '0;
    reads = int'(ln);
    exp_a.delete();
    exp_b.delete();
    for (int i = 0; i < int'(ln); i++) begin
      exp_a.push_back(8'(int'(ba) + i));
      exp_b.push_back(8'(int'(bb) + i));
      if (mem_a[8'(int'(ba) + i)] != mem_b[8'(int'(bb) + i)]) begin
        eq = 1'b0;
        mi = 8'(i);
        reads = i + 1;
        break;
      end
    end
    cyc = (ln == 0) ? 1 : 2 * reads + 1;
  endtask

  // Launch a run and observe a fixed window of cycles after the start edge.
  // Cycle c is the c-th clock period after the edge that samples start.
  task automatic do_run(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] ln,
                        input int window, input int start_at, input int abort_at,
                        output int done_cyc, output int n_done, output int n_reads);
    obs_a.delete();
    obs_b.delete();
    obs_busy.delete();
    done_cyc = -1;
    n_done = 0;
    n_reads = 0;
    @(negedge clk);
    base_a_i = ba;
    base_b_i = bb;
    len_i = ln;
    start_i = 1'b1;
    abort_i = 1'b0;
    for (int c = 1; c <= window; c++) begin
      @(negedge clk);
      if (rd_en === 1'b1) begin
        n_reads++;
        obs_a.push_back(addr_a);
        obs_b.push_back(addr_b);
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      obs_busy.push_back(busy);
      start_i = (c == start_at);
      abort_i = (c == abort_at);
      if (c == start_at) begin
        base_a_i = 8'h33;
        len_i = 8'd7;
      end
    end
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({rd_en, busy, done, equal, mismatch_idx, addr_a, addr_b} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got rd_en=%b busy=%b done=%b equal=%b mi=%h a=%h b=%h want all 0",
               rd_en, busy, done, equal, mismatch_idx, addr_a, addr_b);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rd_en, busy, done} !== 3'b000) begin
      n_errors++;
      $display("FAIL idle_after_reset: got rd_en=%b busy=%b done=%b want 000", rd_en, busy, done);
    end
  endtask

  task automatic test_all_equal();
    int dc, nd, nr, ecyc, erd;
    logic eeq;
    logic [7:0] emi;
    prep(8'h10, 8'h80, 8'd4);
    model(8'h10, 8'h80, 8'd4, eeq, emi, ecyc, erd);
    do_run(8'h10, 8'h80, 8'd4, 13, -1, -1, dc, nd, nr);
    n_checks++;
    if (dc !== 9) begin n_errors++; $display("FAIL all_equal done_cycle: got %0d want 9", dc); end
    n_checks++;
    if (nd !== 1) begin n_errors++; $display("FAIL all_equal done_pulses: got %0d want 1", nd); end
    n_checks++;
    if (equal !== 1'b1 || mismatch_idx !== 8'h00) begin
      n_errors++;
      $display("FAIL all_equal result: got equal=%b mi=%h want 1/00", equal, mismatch_idx);
    end
    n_checks++;
    if (nr !== 4) begin n_errors++; $display("FAIL all_equal reads: got %0d want 4", nr); end
    for (int i = 0; i < nr && i < exp_a.size(); i++) begin
      n_checks++;
      if (obs_a[i] !== exp_a[i] || obs_b[i] !== exp_b[i]) begin
        n_errors++;
        $display("FAIL all_equal addr[%0d]: got %h/%h want %h/%h", i, obs_a[i], obs_b[i], exp_a[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_mismatch();
    int dc, nd, nr;
    prep(8'h10, 8'h80, 8'd4);
    mem_a[8'h12] = 32'hDEADBEEF;
    mem_b[8'h82] = 32'hDEADBEEE;
    do_run(8'h10, 8'h80, 8'd4, 13, -1, -1, dc, nd, nr);
    n_checks++;
    if (dc !== 7) begin n_errors++; $display("FAIL mismatch done_cycle: got %0d want 7", dc); end
    n_checks++;
    if (nr !== 3) begin n_errors++; $display("FAIL mismatch reads: got %0d want 3", nr); end
    n_checks++;
    if (nd !== 1) begin n_errors++; $display("FAIL mismatch done_pulses: got %0d want 1", nd); end
    n_checks++;
    if (equal !== 1'b0 || mismatch_idx !== 8'd2) begin
      n_errors++;
      $display("FAIL mismatch result: got equal=%b mi=%h want 0/02", equal, mismatch_idx);
    end
  endtask

  task automatic test_len_zero();
    int dc, nd, nr;
    do_run(8'h44, 8'h55, 8'd0, 5, -1, -1, dc, nd, nr);
    n_checks++;
    if (dc !== 1) begin n_errors++; $display("FAIL len_zero done_cycle: got %0d want 1", dc); end
    n_checks++;
    if (nr !== 0 || nd !== 1) begin
      n_errors++;
      $display("FAIL len_zero activity: got reads=%0d dones=%0d want 0/1", nr, nd);
    end
    n_checks++;
    if (equal !== 1'b1 || mismatch_idx !== 8'h00) begin
      n_errors++;
      $display("FAIL len_zero result: got equal=%b mi=%h want 1/00", equal, mismatch_idx);
    end
  endtask

  task automatic test_wrap();
    int dc, nd, nr;
    logic [7:0] want [3];
    want = '{8'hFE, 8'hFF, 8'h00};
    prep(8'hFE, 8'h20, 8'd3);
    do_run(8'hFE, 8'h20, 8'd3, 11, -1, -1, dc, nd, nr);
    n_checks++;
    if (nr !== 3) begin n_errors++; $display("FAIL wrap reads: got %0d want 3", nr); end
    for (int i = 0; i < 3 && i < nr; i++) begin
      n_checks++;
      if (obs_a[i] !== want[i]) begin
        n_errors++;
        $display("FAIL wrap addr_a[%0d]: got %h want %h", i, obs_a[i], want[i]);
      end
    end
    n_checks++;
    if (dc !== 7 || equal !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap completion: got cycle=%0d equal=%b want 7/1", dc, equal);
    end
  endtask

  task automatic test_abort();
    int dc, nd, nr, idle_busy;
    // establish a known previous result: mismatch at index 1
    prep(8'h50, 8'h60, 8'd3);
    mem_b[8'h61] = ~mem_a[8'h51];
    do_run(8'h50, 8'h60, 8'd3, 10, -1, -1, dc, nd, nr);
    n_checks++;
    if (equal !== 1'b0 || mismatch_idx !== 8'd1) begin
      n_errors++;
      $display("FAIL abort_setup result: got equal=%b mi=%h want 0/01", equal, mismatch_idx);
    end
    // all-equal len=5 run, aborted in its second COMPARE (cycle 4)
    prep(8'h90, 8'hA0, 8'd5);
    do_run(8'h90, 8'hA0, 8'd5, 12, -1, 4, dc, nd, nr);
    n_checks++;
    if (nd !== 0) begin n_errors++; $display("FAIL abort done_pulses: got %0d want 0", nd); end
    n_checks++;
    if (nr !== 2) begin n_errors++; $display("FAIL abort reads: got %0d want 2", nr); end
    idle_busy = 0;
    for (int i = 4; i < obs_busy.size(); i++) if (obs_busy[i] !== 1'b0) idle_busy++;
    n_checks++;
    if (idle_busy !== 0 || obs_busy[3] !== 1'b1) begin
      n_errors++;
      $display("FAIL abort busy: got busy_in_c4=%b busy_cycles_after=%0d want 1/0", obs_busy[3], idle_busy);
    end
    n_checks++;
    if (equal !== 1'b0 || mismatch_idx !== 8'd1) begin
      n_errors++;
      $display("FAIL abort held_result: got equal=%b mi=%h want 0/01", equal, mismatch_idx);
    end
  endtask

  task automatic test_start_busy();
    int dc, nd, nr;
    // start pulsed during COMPARE (cycle 2), then during DONE (cycle 7)
    for (int k = 0; k < 2; k++) begin
      prep(8'h00, 8'hC0, 8'd3);
      do_run(8'h00, 8'hC0, 8'd3, 14, (k == 0) ? 2 : 7, -1, dc, nd, nr);
      n_checks++;
      if (nr !== 3 || nd !== 1 || dc !== 7) begin
        n_errors++;
        $display("FAIL start_busy[%0d]: got reads=%0d dones=%0d cycle=%0d want 3/1/7", k, nr, nd, dc);
      end
    end
  endtask

  task automatic test_random();
    int dc, nd, nr, ecyc, erd, k;
    logic eeq;
    logic [7:0] emi, ba, bb, ln;
    for (int it = 0; it < 25; it++) begin
      ba = 8'($urandom);
      bb = 8'($urandom);
      ln = 8'($urandom_range(0, 12));
      prep(ba, bb, ln);
      if (ln != 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, int'(ln) - 1);
        mem_b[8'(int'(bb) + k)] ^= (32'h1 << $urandom_range(0, 31));
      end
      model(ba, bb, ln, eeq, emi, ecyc, erd);
      do_run(ba, bb, ln, 2 * int'(ln) + 5, -1, -1, dc, nd, nr);
      n_checks++;
      if (dc !== ecyc || nd !== 1) begin
        n_errors++;
        $display("FAIL random[%0d] timing: got cycle=%0d dones=%0d want %0d/1", it, dc, nd, ecyc);
      end
      n_checks++;
      if (equal !== eeq || mismatch_idx !== emi) begin
        n_errors++;
        $display("FAIL random[%0d] result: got equal=%b mi=%h want %b/%h", it, equal, mismatch_idx, eeq, emi);
      end
      n_checks++;
      if (nr !== erd) begin
        n_errors++;
        $display("FAIL random[%0d] reads: got %0d want %0d", it, nr, erd);
      end
      for (int i = 0; i < nr && i < exp_a.size(); i++) begin
        n_checks++;
        if (obs_a[i] !== exp_a[i] || obs_b[i] !== exp_b[i]) begin
          n_errors++;
          $display("FAIL random[%0d] addr[%0d]: got %h/%h want %h/%h", it, i, obs_a[i], obs_b[i], exp_a[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    int dc, nd, nr, ecyc, erd;
    logic eeq;
    logic [7:0] emi;
    // previous result equal=1 so the reset clearing it is visible
    prep(8'h40, 8'h48, 8'd6);
    do_run(8'h40, 8'h48, 8'd1, 6, -1, -1, dc, nd, nr);
    @(negedge clk);
    base_a_i = 8'h40;
    base_b_i = 8'h48;
    len_i = 8'd6;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({rd_en, busy, done, equal, mismatch_idx, addr_a, addr_b} !== '0) begin
      n_errors++;
      $display("FAIL midrun_reset: got rd_en=%b busy=%b done=%b equal=%b mi=%h a=%h b=%h want all 0",
               rd_en, busy, done, equal, mismatch_idx, addr_a, addr_b);
    end
    @(negedge clk);
    n_checks++;
    if ({rd_en, busy, done} !== 3'b000) begin
      n_errors++;
      $display("FAIL midrun_reset_hold: got rd_en=%b busy=%b done=%b want 000", rd_en, busy, done);
    end
    rst = 1'b1;
    prep(8'h70, 8'h08, 8'd5);
    model(8'h70, 8'h08, 8'd5, eeq, emi, ecyc, erd);
    do_run(8'h70, 8'h08, 8'd5, 15, -1, -1, dc, nd, nr);
    n_checks++;
    if (dc !== ecyc || nd !== 1 || nr !== erd || equal !== eeq) begin
      n_errors++;
      $display("FAIL after_reset_run: got cycle=%0d dones=%0d reads=%0d equal=%b want %0d/1/%0d/%b",
               dc, nd, nr, equal, ecyc, erd, eeq);
    end
  endtask

  initial begin
    test_reset();
    test_all_equal();
    test_mismatch();
    test_len_zero();
    test_wrap();
    test_abort();
    test_start_busy();
    test_random();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/block_compare_ctrl.md
BLOCK_COMPARE_CTRL -- requirements
Module: block_compare_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning the data word width in bits.
REQ-002 The block SHALL have parameter AW, default 8, meaning the address, length and index width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request a compare run; sampled only in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: synchronous cancel of a run in progress.
REQ-007 The block SHALL have ports base_a and base_b, input, AW bits each: start addresses of buffers A and B; captured on an accepted start.
REQ-008 The block SHALL have port len, input, AW bits: number of words to compare; captured on an accepted start.
REQ-009 The block SHALL have port rd_en, output, 1 bit: read strobe to both memories.
REQ-010 The block SHALL have ports addr_a and addr_b, output, AW bits each: read addresses, valid while rd_en=1.
REQ-011 The block SHALL have ports rd_data_a and rd_data_b, input, N bits each: read data, valid exactly one cycle after rd_en.
REQ-012 The block SHALL have port busy, output, 1 bit: high in READ and COMPARE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when a run completes.
REQ-014 The block SHALL have port equal, output, 1 bit: result of the last completed run.
REQ-015 The block SHALL have port mismatch_idx, output, AW bits: word index of the first mismatch of the last completed run.

Function
REQ-016 The FSM SHALL have states IDLE, READ, COMPARE and DONE, with state, index, captured bases and captured length held in registers.
REQ-017 In IDLE, start=1 with len!=0 SHALL capture base_a, base_b and len, clear the index to 0, and go to READ.
REQ-018 In IDLE, start=1 with len=0 SHALL go directly to DONE with equal=1 and mismatch_idx=0.
REQ-019 READ SHALL drive rd_en=1, addr_a=base_a+idx and addr_b=base_b+idx, with the sums truncated to AW bits (wrap modulo 2^AW), then go to COMPARE.
REQ-020 COMPARE SHALL test rd_data_a==rd_data_b over all N bits using one shared N-bit equality comparator.
REQ-021 In COMPARE, a mismatch SHALL go to DONE with equal=0 and mismatch_idx=idx (early exit; no further reads).
REQ-022 In COMPARE, a match with idx==len-1 SHALL go to DONE with equal=1 and mismatch_idx=0.
REQ-023 In COMPARE, a match otherwise SHALL increment idx and go to READ.
REQ-024 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-025 equal and mismatch_idx SHALL update only on entry to DONE and SHALL hold until the next entry to DONE.
REQ-026 rd_en SHALL be 0 in every state other than READ.
REQ-027 start in READ, COMPARE or DONE SHALL be ignored and SHALL not be queued.
REQ-028 abort=1 in READ or COMPARE SHALL return to IDLE on the next edge, with no done pulse and equal and mismatch_idx unchanged; abort has priority over the compare result.
REQ-029 abort in IDLE or DONE SHALL have no effect.
REQ-030 Latency SHALL be: an all-match run of L words pulses done in cycle 2L+1 after the start edge; a first mismatch at index k pulses done in cycle 2k+3.

Reset
REQ-031 rst=0 SHALL immediately force state=IDLE, idx=0, captured bases and length=0, rd_en=0, busy=0, done=0, equal=0 and mismatch_idx=0, regardless of clk.
REQ-032 Reset asserted mid-run SHALL abandon the run with no done pulse; operation SHALL resume on the first clock edge after rst returns to 1.

Verification
REQ-033 The bench SHALL cover: base_a=0x10, base_b=0x80, len=4, all words equal -> reads at idx 0..3, done in cycle 9, equal=1, mismatch_idx=0.
REQ-034 The bench SHALL cover: len=4 with words differing at idx 2 (A=0xDEADBEEF, B=0xDEADBEEE) -> exactly 3 reads, done in cycle 7, equal=0, mismatch_idx=2.
REQ-035 The bench SHALL cover: len=0 -> no rd_en, done in cycle 1, equal=1.
REQ-036 The bench SHALL cover: base_a=0xFE, len=3 -> addr_a sequence 0xFE, 0xFF, 0x00.
REQ-037 The bench SHALL cover: abort in the second COMPARE of a len=5 run -> IDLE next cycle, no done, prior equal and mismatch_idx held; start pulsed while busy -> ignored.
REQ-038 The bench SHALL cover: rst=0 asserted mid-run between clock edges -> all outputs 0 immediately; a new start after release completes normally.
